// File: rtl/stereo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stereo_pkg: shared FSM encoding and default image geometry          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package stereo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int DEFAULT_IMG_ROWS      = 320;
    localparam int DEFAULT_WORDS_PER_ROW = 40;
    localparam int DEFAULT_WORD_W        = 48;

endpackage
`default_nettype wire

// File: rtl/fetch_tag_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_tag_pipe: valid/tag shift register matching BRAM read latency |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module fetch_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             clr_in,
    input  logic             valid_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    output logic [TAG_W-1:0] tag_out
);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;

    always_comb begin
        valid_d    = '0;
        tag_d      = '0;
        valid_d[0] = valid_in;
        tag_d[0]   = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (clr_in) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_out = valid_q[DEPTH-1];
    assign tag_out   = tag_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/stereo_block_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stereo_block_fetch: fetches ROWS rows per channel into a ping-pong  |
// | buffer bank, with bottom-edge row replication. Revision: 1.0        |
// +--------------------------------------------------------------------+
module stereo_block_fetch
    import stereo_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int ROWS          = 6,
    parameter int WORD_W        = DEFAULT_WORD_W,
    parameter int WORDS_PER_ROW = DEFAULT_WORDS_PER_ROW,
    parameter int IMG_ROWS      = DEFAULT_IMG_ROWS,
    parameter int READ_LATENCY  = 2,
    localparam int X_W          = $clog2(WORDS_PER_ROW),
    localparam int Y_W          = $clog2(IMG_ROWS),
    localparam int ADDR_W       = $clog2(WORDS_PER_ROW * IMG_ROWS)
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      req_valid_in,
    output logic                                      req_ready_out,
    input  logic                                      bank_in,
    input  logic [NUM_CH-1:0][X_W-1:0]                x_in,
    input  logic [NUM_CH-1:0][Y_W-1:0]                y_in,
    output logic                                      rd_en_out,
    output logic [NUM_CH-1:0][ADDR_W-1:0]             addr_out,
    input  logic [NUM_CH-1:0][WORD_W-1:0]             dout_in,
    output logic [NUM_CH-1:0][1:0][ROWS-1:0][WORD_W-1:0] buf_out,
    output logic                                      done_out
);

    localparam int              RW       = $clog2(ROWS) + 1;
    localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);
    localparam logic [Y_W:0]    Y_MAX    = (Y_W + 1)'(IMG_ROWS - 1);

    fetch_state_t                         state_q, state_d;
    logic [RW-1:0]                        row_q, row_d, sel_row;
    logic [NUM_CH-1:0][X_W-1:0]           x_q, x_d, sel_x;
    logic [NUM_CH-1:0][Y_W-1:0]           y_q, y_d, sel_y;
    logic [NUM_CH-1:0][ADDR_W-1:0]        addr_q, addr_d, row_addr;
    logic                                 bank_q, bank_d;
    logic                                 rd_en_q, rd_en_d;
    logic                                 done_q, done_d;
    logic [NUM_CH-1:0][1:0][ROWS-1:0][WORD_W-1:0] buf_q, buf_d;
    logic                                 pipe_valid;
    logic [RW-1:0]                        pipe_tag;

    // The first address is formed straight from the request inputs so that
    // row 0 is on the bus in the cycle right after the accept.
    always_comb begin
        sel_x   = x_q;
        sel_y   = y_q;
        sel_row = row_q + RW'(1);
        if (state_q == IDLE) begin
            sel_x   = x_in;
            sel_y   = y_in;
            sel_row = '0;
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_addr
            logic [Y_W:0] row_sum;
            logic [Y_W:0] row_clamped;
            assign row_sum     = {1'b0, sel_y[c]} + (Y_W + 1)'(sel_row);
            assign row_clamped = (row_sum > Y_MAX) ? Y_MAX : row_sum;
            assign row_addr[c] = ADDR_W'(row_clamped) * ADDR_W'(WORDS_PER_ROW)
                               + ADDR_W'(sel_x[c]);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        bank_d  = bank_q;
        x_d     = x_q;
        y_d     = y_q;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    state_d = ISSUE;
                    bank_d  = bank_in;
                    x_d     = x_in;
                    y_d     = y_in;
                    row_d   = '0;
                    rd_en_d = 1'b1;
                    addr_d  = row_addr;
                end
            end
            ISSUE: begin
                if (row_q == LAST_ROW) begin
                    state_d = DRAIN;
                end else begin
                    row_d   = row_q + RW'(1);
                    rd_en_d = 1'b1;
                    addr_d  = row_addr;
                end
            end
            DRAIN: begin
                if (pipe_valid && (pipe_tag == LAST_ROW)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        if (pipe_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                buf_d[c][bank_q][pipe_tag] = dout_in[c];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            row_q   <= '0;
            bank_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            bank_q  <= bank_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            buf_q   <= buf_d;
        end
    end

    // Reset doubles as the pipe clear so aborted reads never land in a buffer.
    fetch_tag_pipe #(
        .DEPTH (READ_LATENCY),
        .TAG_W (RW)
    ) u_tag_pipe (
        .clk_in    (clk_in),
        .clr_in    (rst_in),
        .valid_in  (rd_en_q),
        .tag_in    (row_q),
        .valid_out (pipe_valid),
        .tag_out   (pipe_tag)
    );

    assign req_ready_out = (state_q == IDLE);
    assign rd_en_out     = rd_en_q;
    assign addr_out      = addr_q;
    assign buf_out       = buf_q;
    assign done_out      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stereo_block_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stereo_block_fetch: scoreboard bench for stereo_block_fetch      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_stereo_block_fetch;

    localparam int NUM_CH = 2;
    localparam int ROWS   = 6;
    localparam int WORD_W = 48;
    localparam int WPR    = 40;
    localparam int IMG    = 320;
    localparam int LAT    = 2;
    localparam int X_W    = 6;
    localparam int Y_W    = 9;
    localparam int ADDR_W = 14;
    localparam int NCH2   = 4;
    localparam int ROWS2  = 3;

    typedef logic [NUM_CH-1:0][1:0][ROWS-1:0][WORD_W-1:0] buf_t;
    typedef logic [NCH2-1:0][1:0][ROWS2-1:0][WORD_W-1:0]  buf2_t;
    typedef logic [NUM_CH-1:0][ADDR_W-1:0]                addrv_t;
    typedef struct { int cyc; addrv_t addr; } addr_ent_t;
    typedef struct { int cyc; buf_t buff; }   done_ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst, req_valid, req_ready, bank, rd_en, done;
    logic [NUM_CH-1:0][X_W-1:0] x_in;
    logic [NUM_CH-1:0][Y_W-1:0] y_in;
    addrv_t                     addr;
    logic [NUM_CH-1:0][WORD_W-1:0] dout;
    buf_t                       buf_o;

    logic                       rv2, rdy2, bank2, rd2, done2;
    logic [NCH2-1:0][X_W-1:0]   x2;
    logic [NCH2-1:0][Y_W-1:0]   y2;
    logic [NCH2-1:0][ADDR_W-1:0] addr2, b2_q;
    logic [NCH2-1:0][WORD_W-1:0] dout2;
    buf2_t                      buf2;

    int        cyc = 0;
    int        checks = 0;
    int        failures = 0;
    bit        mon_en = 1'b0;
    addr_ent_t addr_sb[$];
    done_ent_t done_sb[$];
    addr_ent_t mon_a;
    done_ent_t mon_d;
    buf_t      model_buf = '0;
    addrv_t    bram_pipe [LAT];

    stereo_block_fetch u_dut (
        .clk_in (clk), .rst_in (rst), .req_valid_in (req_valid), .req_ready_out (req_ready),
        .bank_in (bank), .x_in (x_in), .y_in (y_in), .rd_en_out (rd_en), .addr_out (addr),
        .dout_in (dout), .buf_out (buf_o), .done_out (done)
    );

    stereo_block_fetch #(.NUM_CH (NCH2), .ROWS (ROWS2), .READ_LATENCY (1)) u_dut6 (
        .clk_in (clk), .rst_in (rst), .req_valid_in (rv2), .req_ready_out (rdy2),
        .bank_in (bank2), .x_in (x2), .y_in (y2), .rd_en_out (rd2), .addr_out (addr2),
        .dout_in (dout2), .buf_out (buf2), .done_out (done2)
    );

    function automatic logic [WORD_W-1:0] bram_word(input int c, input logic [ADDR_W-1:0] a);
        return (WORD_W'(c) << ADDR_W) | WORD_W'(a);
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input int y, input int x, input int r);
        int row;
        row = y + r;
        if (row > IMG - 1) row = IMG - 1;
        return ADDR_W'(row * WPR + x);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bram_pipe[0] <= addr;
        for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
        b2_q <= addr2;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) dout[c] = bram_word(c, bram_pipe[LAT-1][c]);
        for (int c = 0; c < NCH2; c++) dout2[c] = bram_word(c, b2_q[c]);
    end

    task automatic check(input string nm, input logic [1151:0] act, input logic [1151:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rd_en) begin
            if (addr_sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got read at cycle %0d expected none", cyc);
            end else begin
                mon_a = addr_sb.pop_front();
                check("rd_cycle", cyc, mon_a.cyc);
                check("rd_addr", addr, mon_a.addr);
            end
        end
        if (mon_en && done) begin
            if (done_sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
            end else begin
                mon_d = done_sb.pop_front();
                check("done_cycle", cyc, mon_d.cyc);
                check("ready_in_done", req_ready, 1'b1);
                check("buffer", buf_o, mon_d.buff);
            end
        end
    end

    // Issues one request in the current cycle and returns in its done cycle.
    task automatic do_fetch(input logic bnk, input int x0, input int x1,
                            input int y0, input int y1, input bit noise);
        int t0;
        addr_ent_t a;
        done_ent_t d;
        t0 = cyc;
        req_valid = 1'b1;
        bank      = bnk;
        x_in[0]   = X_W'(x0);
        x_in[1]   = X_W'(x1);
        y_in[0]   = Y_W'(y0);
        y_in[1]   = Y_W'(y1);
        for (int r = 0; r < ROWS; r++) begin
            a.cyc     = t0 + 1 + r;
            a.addr[0] = exp_addr(y0, x0, r);
            a.addr[1] = exp_addr(y1, x1, r);
            addr_sb.push_back(a);
            model_buf[0][bnk][r] = bram_word(0, a.addr[0]);
            model_buf[1][bnk][r] = bram_word(1, a.addr[1]);
        end
        d.cyc  = t0 + ROWS + LAT + 1;
        d.buff = model_buf;
        done_sb.push_back(d);
        for (int k = 1; k <= ROWS + LAT; k++) begin
            @(posedge clk); #1;
            check("ready_busy", req_ready, 1'b0);
            if (noise) begin
                req_valid = 1'b1;
                bank      = ~bnk;
                x_in[0]   = X_W'($urandom_range(0, WPR - 1));
                x_in[1]   = X_W'($urandom_range(0, WPR - 1));
                y_in[0]   = Y_W'($urandom_range(0, IMG - 1));
                y_in[1]   = Y_W'($urandom_range(0, IMG - 1));
            end else begin
                req_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, rd_cnt, done_cnt, done_cyc;
        addr_ent_t a;
        logic [NCH2-1:0][ADDR_W-1:0] e2;
        buf2_t exp2;
        int xs2 [NCH2];
        int ys2 [NCH2];

        rst = 1'b1; req_valid = 1'b0; bank = 1'b0; x_in = '0; y_in = '0;
        rv2 = 1'b0; bank2 = 1'b0; x2 = '0; y2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_addr", addr, '0);
        check("rst_done", done, 1'b0);
        check("rst_buf", buf_o, '0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle_cycle();

        do_fetch(1'b0, 5, 3, 0, 0, 1'b0);
        idle_cycle();
        do_fetch(1'b1, 5, 3, 317, 100, 1'b0);
        idle_cycle();
        do_fetch(1'b0, 1, 2, 10, 20, 1'b0);
        do_fetch(1'b1, 39, 0, 50, 319, 1'b0);
        idle_cycle();
        do_fetch(1'b0, 20, 30, 200, 300, 1'b1);
        idle_cycle();

        // Reset asserted during cycle 4 of a fetch.
        t0 = cyc;
        req_valid = 1'b1; bank = 1'b0;
        x_in[0] = X_W'(5); x_in[1] = X_W'(3); y_in = '0;
        for (int r = 0; r < 4; r++) begin
            a.cyc     = t0 + 1 + r;
            a.addr[0] = exp_addr(0, 5, r);
            a.addr[1] = exp_addr(0, 3, r);
            addr_sb.push_back(a);
        end
        idle_cycle();
        req_valid = 1'b0;
        repeat (3) idle_cycle();
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        model_buf = '0;
        check("abort_ready", req_ready, 1'b1);
        check("abort_rd_en", rd_en, 1'b0);
        check("abort_addr", addr, '0);
        check("abort_done", done, 1'b0);
        check("abort_buf", buf_o, '0);
        repeat (10) idle_cycle();
        check("abort_buf_late", buf_o, '0);

        // Smaller configuration: 4 channels, 3 rows, latency 1.
        xs2 = '{5, 3, 7, 9};
        ys2 = '{0, 0, 318, 100};
        exp2 = '0;
        for (int c = 0; c < NCH2; c++) begin
            x2[c] = X_W'(xs2[c]);
            y2[c] = Y_W'(ys2[c]);
            for (int r = 0; r < ROWS2; r++) exp2[c][0][r] = bram_word(c, exp_addr(ys2[c], xs2[c], r));
        end
        t0 = cyc; rv2 = 1'b1; bank2 = 1'b0;
        rd_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int k = 1; k <= 12; k++) begin
            idle_cycle();
            rv2 = 1'b0;
            if (rd2) begin
                for (int c = 0; c < NCH2; c++) e2[c] = exp_addr(ys2[c], xs2[c], rd_cnt);
                check("d6_addr", addr2, e2);
                rd_cnt++;
            end
            if (done2) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        check("d6_reads", rd_cnt, ROWS2);
        check("d6_done_count", done_cnt, 1);
        check("d6_done_cycle", done_cyc, t0 + 5);
        check("d6_buffer", buf2, exp2);

        check("addr_sb_left", addr_sb.size(), 0);
        check("done_sb_left", done_sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
